// File: rtl/beta_irq_ctrl.sv
// beta_irq_ctrl: fixed-priority interrupt controller for the Beta CPU.
//
// The controller registers NUM_IRQ request lines. Each line can be edge- or
// level-triggered, and each has a software mask bit. The lowest pending,
// enabled channel wins and is presented to the CU as one IRQ. The block also
// supplies a registered handler vector (XADDR) and channel ID, and keeps an
// in-service mask until the handler signals end-of-interrupt.
//
// Optional feature (compile-time macro IRQ_NESTING_EN):
//   defined   - a higher-priority request may preempt a running handler, so
//               ISR can hold several bits and EOI retires them innermost first.
//   undefined - no preemption: ISR holds at most one bit, and EOI always
//               returns to IDLE.
//
// Reset is synchronous and active-low (RESET_N).
`timescale 1ns/1ps

module beta_irq_ctrl #(
    parameter int                 NUM_IRQ    = 8,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK  = {NUM_IRQ{1'b1}},
    parameter logic [31:0]        XADDR_BASE = 32'h0000_0008,
    parameter int                 VEC_STRIDE = 4
) (
    input  logic                       CLK,
    input  logic                       RESET_N,
    input  logic [NUM_IRQ-1:0]         IRQ_IN,
    input  logic                       MASK_WE,
    input  logic [NUM_IRQ-1:0]         MASK_WD,
    input  logic                       SUPERVISOR,
    input  logic                       IRQ_ACK,
    input  logic                       EOI,
    output logic                       IRQ,
    output logic [$clog2(NUM_IRQ)-1:0] IRQ_ID,
    output logic [31:0]                XADDR,
    output logic [NUM_IRQ-1:0]         ISR
);

    localparam int ID_W = $clog2(NUM_IRQ);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_SVC  = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    // Registered state
    logic [NUM_IRQ-1:0] in_q;   // synchronised request lines
    logic [NUM_IRQ-1:0] in_p;   // in_q one cycle earlier, for edge detection
    logic [NUM_IRQ-1:0] pend;   // latched edge requests (edge channels only)
    logic [NUM_IRQ-1:0] mask;   // 1 = channel enabled
    logic [NUM_IRQ-1:0] isr;    // in-service channels

    // Combinational arbitration signals
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] cand;
    logic               cand_any;
    logic [ID_W-1:0]    win_id;
    logic               isr_any;
    logic [ID_W-1:0]    isr_low;
    logic               outranks;
    logic               arb_go;
    logic               latched_live;

    // Combinational update signals
    logic               ack_take;
    logic               eoi_take;
    logic [NUM_IRQ-1:0] ack_set;
    logic [NUM_IRQ-1:0] eoi_clr;
    logic [NUM_IRQ-1:0] isr_nx;
    logic [NUM_IRQ-1:0] pend_nx;
    logic               id_load;

    // A rising edge is used in the same cycle it is detected. It is also
    // latched into pend so that it survives after the line drops.
    assign rise    = in_q & ~in_p & EDGE_MASK;
    assign pending = pend | rise | (in_q & ~EDGE_MASK);
    assign cand    = pending & mask;

    // Lowest-index candidate wins (channel 0 has the highest priority)
    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // otherwise a path that skips the assignment infers a latch.
        cand_any = 1'b0;
        win_id   = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                cand_any = 1'b1;
                win_id   = ID_W'(i);
            end
        end
    end

    // Highest-priority channel currently in service
    always_comb begin
        isr_any = 1'b0;
        isr_low = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (isr[i]) begin
                isr_any = 1'b1;
                isr_low = ID_W'(i);
            end
        end
    end

`ifdef IRQ_NESTING_EN
    assign outranks = !isr_any || (win_id < isr_low);
`else
    assign outranks = !isr_any;
`endif

    assign arb_go       = cand_any && outranks && !SUPERVISOR;
    assign latched_live = cand[IRQ_ID];

    // The ISR set/clear and the PEND clear are independent per-channel
    // masks, so a set and a clear on different channels in one cycle both
    // take effect. A fresh edge on the acknowledged channel wins over its
    // clear.
    assign ack_take = (state == S_REQ) && IRQ_ACK;
    assign eoi_take = EOI && isr_any;
    assign ack_set  = ack_take ? (NUM_IRQ'(1) << IRQ_ID) : '0;
    assign eoi_clr  = eoi_take ? (NUM_IRQ'(1) << isr_low) : '0;
    assign isr_nx   = (isr & ~eoi_clr) | ack_set;
    assign pend_nx  = (pend & ~(ack_set & EDGE_MASK)) | rise;

    // Next-state logic for IDLE -> REQ -> SVC; id_load latches the winner
    always_comb begin
        state_nx = state;
        id_load  = 1'b0;
        case (state)
            S_IDLE: begin
                if (arb_go) begin
                    state_nx = S_REQ;
                    id_load  = 1'b1;
                end
            end
            S_REQ: begin
                if (ack_take) begin
                    state_nx = S_SVC;
                end else if (!latched_live) begin
                    // Request withdrawn before acknowledge. If an outer
                    // handler is still in service (nesting), return to it.
                    state_nx = (isr_nx != '0) ? S_SVC : S_IDLE;
                end
            end
            S_SVC: begin
                // After EOI, re-arbitrate only in the next cycle, against
                // the updated ISR.
                if (eoi_take) begin
                    if (isr_nx == '0) begin
                        state_nx = S_IDLE;
                    end
                end
`ifdef IRQ_NESTING_EN
                else if (arb_go) begin
                    state_nx = S_REQ;
                    id_load  = 1'b1;
                end
`endif
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State, input pipeline, pending, mask, ISR and vector registers
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register samples pre-edge values and process order does not matter.
        if (!RESET_N) begin
            state  <= S_IDLE;
            in_q   <= '0;
            in_p   <= '0;
            pend   <= '0;
            mask   <= '0;
            isr    <= '0;
            IRQ_ID <= '0;
            XADDR  <= XADDR_BASE;
        end else begin
            state <= state_nx;
            in_q  <= IRQ_IN;
            in_p  <= in_q;
            pend  <= pend_nx;
            isr   <= isr_nx;
            if (MASK_WE) begin
                mask <= MASK_WD;
            end
            if (id_load) begin
                IRQ_ID <= win_id;
                XADDR  <= XADDR_BASE + (32'(win_id) * 32'(VEC_STRIDE));
            end
        end
    end

    // SUPERVISOR masks the request combinationally; the FSM stays in REQ
    assign IRQ = (state == S_REQ) && !SUPERVISOR;
    assign ISR = isr;

endmodule

// File: tb/tb_beta_irq_ctrl.sv
// tb_beta_irq_ctrl: directed self-checking bench for beta_irq_ctrl.
// Channel 1 is level-triggered; all other channels are edge-triggered.
// Inputs change and outputs are sampled 1 ns after each rising edge.
`timescale 1ns/1ps

module tb_beta_irq_ctrl;

    logic        clk;
    logic        rst_n;
    logic [7:0]  irq_in;
    logic        mask_we;
    logic [7:0]  mask_wd;
    logic        supervisor;
    logic        irq_ack;
    logic        eoi;
    logic        irq;
    logic [2:0]  irq_id;
    logic [31:0] xaddr;
    logic [7:0]  isr;

    int n_checks = 0;
    int n_fail   = 0;

    beta_irq_ctrl #(
        .NUM_IRQ    (8),
        .EDGE_MASK  (8'hFD),
        .XADDR_BASE (32'h0000_0008),
        .VEC_STRIDE (4)
    ) dut (
        .CLK        (clk),
        .RESET_N    (rst_n),
        .IRQ_IN     (irq_in),
        .MASK_WE    (mask_we),
        .MASK_WD    (mask_wd),
        .SUPERVISOR (supervisor),
        .IRQ_ACK    (irq_ack),
        .EOI        (eoi),
        .IRQ        (irq),
        .IRQ_ID     (irq_id),
        .XADDR      (xaddr),
        .ISR        (isr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mask(input logic [7:0] m);
        mask_we = 1'b1;
        mask_wd = m;
        step();
        mask_we = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        irq_in     = 8'hFF;
        mask_we    = 1'b0;
        mask_wd    = 8'h00;
        supervisor = 1'b0;
        irq_ack    = 1'b0;
        eoi        = 1'b0;

        // 1) Reset with all lines high and the mask unwritten
        step();
        step();
        check("rst_irq",    32'(irq),    32'h0);
        check("rst_id",     32'(irq_id), 32'h0);
        check("rst_xaddr",  xaddr,       32'h8);
        check("rst_isr",    32'(isr),    32'h0);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            check("masked_irq",   32'(irq), 32'h0);
            check("masked_isr",   32'(isr), 32'h0);
            check("masked_xaddr", xaddr,    32'h8);
        end

        // 2) Single pulse on channel 3
        irq_in = 8'h00;
        do_reset();
        step();
        write_mask(8'h08);
        irq_in = 8'h08;
        step();
        check("ch3_lat1_irq", 32'(irq), 32'h0);
        irq_in = 8'h00;
        step();
        check("ch3_irq",   32'(irq),    32'h1);
        check("ch3_id",    32'(irq_id), 32'h3);
        check("ch3_xaddr", xaddr,       32'h14);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check("ch3_ack_irq", 32'(irq), 32'h0);
        check("ch3_ack_isr", 32'(isr), 32'h08);
        step();
        check("ch3_svc_isr", 32'(isr), 32'h08);
        check("ch3_svc_id",  32'(irq_id), 32'h3);
        eoi = 1'b1;
        step();
        eoi = 1'b0;
        check("ch3_eoi_isr", 32'(isr), 32'h0);
        step();
        check("ch3_idle_irq", 32'(irq), 32'h0);
        // A stray acknowledge or EOI outside its state changes nothing
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check("stray_ack_isr", 32'(isr), 32'h0);
        eoi = 1'b1;
        step();
        eoi = 1'b0;
        check("stray_eoi_isr", 32'(isr), 32'h0);
        check("stray_eoi_irq", 32'(irq), 32'h0);

        // 3) Channels 5 and 2 rise together: 2 first, then 5
        write_mask(8'hFF);
        irq_in = 8'h24;
        step();
        step();
        check("pri_irq",   32'(irq),    32'h1);
        check("pri_id",    32'(irq_id), 32'h2);
        check("pri_xaddr", xaddr,       32'h10);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check("pri_isr2", 32'(isr), 32'h04);
        eoi = 1'b1;
        step();
        eoi = 1'b0;
        check("pri_eoi_isr", 32'(isr), 32'h0);
        check("pri_eoi_irq", 32'(irq), 32'h0);
        step();
        check("pri2_irq",   32'(irq),    32'h1);
        check("pri2_id",    32'(irq_id), 32'h5);
        check("pri2_xaddr", xaddr,       32'h1C);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check("pri2_isr", 32'(isr), 32'h20);
        eoi = 1'b1;
        step();
        eoi = 1'b0;
        check("pri2_eoi_isr", 32'(isr), 32'h0);
        irq_in = 8'h00;
        step();
        step();

        // 4) Level channel 1 withdrawn before acknowledge
        irq_in = 8'h02;
        step();
        step();
        check("lvl_irq",   32'(irq),    32'h1);
        check("lvl_id",    32'(irq_id), 32'h1);
        check("lvl_xaddr", xaddr,       32'hC);
        irq_in = 8'h00;
        step();
        check("lvl_hold_irq", 32'(irq), 32'h1);
        step();
        check("lvl_drop_irq", 32'(irq), 32'h0);
        check("lvl_drop_isr", 32'(isr), 32'h0);
        step();
        check("lvl_stay_irq", 32'(irq), 32'h0);

        // SUPERVISOR blocks arbitration, then gates IRQ while in REQ
        supervisor = 1'b1;
        irq_in = 8'h01;
        step();
        step();
        check("sup_blk_irq1", 32'(irq), 32'h0);
        step();
        check("sup_blk_irq2", 32'(irq), 32'h0);
        supervisor = 1'b0;
        step();
        check("sup_rel_irq",   32'(irq),    32'h1);
        check("sup_rel_id",    32'(irq_id), 32'h0);
        check("sup_rel_xaddr", xaddr,       32'h8);
        supervisor = 1'b1;
        #1;
        check("sup_gate_irq", 32'(irq), 32'h0);
        step();
        check("sup_gate_hold", 32'(irq), 32'h0);
        supervisor = 1'b0;
        #1;
        check("sup_ungate_irq", 32'(irq), 32'h1);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check("sup_isr", 32'(isr), 32'h01);
        eoi = 1'b1;
        step();
        eoi = 1'b0;
        check("sup_eoi_isr", 32'(isr), 32'h0);
        irq_in = 8'h00;
        step();

        // 5) In service for channel 4, channel 1 (level) rises
        irq_in = 8'h10;
        step();
        step();
        check("nst_ch4_id",    32'(irq_id), 32'h4);
        check("nst_ch4_xaddr", xaddr,       32'h18);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check("nst_ch4_isr", 32'(isr), 32'h10);
        irq_in = 8'h12;
        step();
        step();
`ifdef IRQ_NESTING_EN
        check("nst_pre_irq", 32'(irq),    32'h1);
        check("nst_pre_id",  32'(irq_id), 32'h1);
        irq_ack = 1'b1;
        irq_in  = 8'h10;
        step();
        irq_ack = 1'b0;
        check("nst_two_isr", 32'(isr), 32'h12);
        check("nst_two_irq", 32'(irq), 32'h0);
        eoi = 1'b1;
        step();
        check("nst_eoi1_isr", 32'(isr), 32'h10);
        check("nst_eoi1_irq", 32'(irq), 32'h0);
        step();
        eoi = 1'b0;
        check("nst_eoi2_isr", 32'(isr), 32'h0);
`else
        check("nst_no_pre_irq", 32'(irq), 32'h0);
        check("nst_no_pre_isr", 32'(isr), 32'h10);
        step();
        check("nst_no_pre_irq2", 32'(irq), 32'h0);
        eoi = 1'b1;
        step();
        eoi = 1'b0;
        check("nst_eoi_isr", 32'(isr), 32'h0);
        check("nst_eoi_irq", 32'(irq), 32'h0);
        step();
        check("nst_next_irq",   32'(irq),    32'h1);
        check("nst_next_id",    32'(irq_id), 32'h1);
        check("nst_next_xaddr", xaddr,       32'hC);
        irq_ack = 1'b1;
        irq_in  = 8'h10;
        step();
        irq_ack = 1'b0;
        check("nst_next_isr", 32'(isr), 32'h02);
        eoi = 1'b1;
        step();
        eoi = 1'b0;
        check("nst_next_eoi_isr", 32'(isr), 32'h0);
`endif
        irq_in = 8'h00;
        step();
        step();

        // 6) Reset while in REQ with acknowledge asserted
        irq_in = 8'h08;
        step();
        step();
        check("rreq_irq", 32'(irq),    32'h1);
        check("rreq_id",  32'(irq_id), 32'h3);
        rst_n   = 1'b0;
        irq_ack = 1'b1;
        step();
        check("rreq_rst_irq",   32'(irq),    32'h0);
        check("rreq_rst_isr",   32'(isr),    32'h0);
        check("rreq_rst_id",    32'(irq_id), 32'h0);
        check("rreq_rst_xaddr", xaddr,       32'h8);
        rst_n   = 1'b1;
        irq_ack = 1'b0;
        // Mask is back to zero: the held line produces no request
        for (int c = 0; c < 5; c++) begin
            step();
            check("rreq_mask_irq", 32'(irq), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
